// File: rtl/hl_pkg.sv
// ---------------------------------------------------------------------------
// hl_pkg
//   Shared definitions for the input-channel controller in front of dec_hl.
//   - Flit type codes (low two bits of every flit).
//   - Head flit field offsets: um_type, src_pos, uni_dst, mult_dst.
//   - U-mesh state codes and multicast-table enable codes returned by dec_hl.
//   - Controller FSM state encoding.
// ---------------------------------------------------------------------------
package hl_pkg;

    // Head flit layout, LSB first:
    //   [1:0]   flit type
    //   [2]     um_type (1 = multicast)
    //   [4:3]   src_pos
    //   [9:5]   uni_dst
    //   [29:10] mult_dst
    //   [FLITW-1:30] payload
    localparam int FT_LSB       = 0;
    localparam int FT_W         = 2;
    localparam int UM_TYPE_BIT  = 2;
    localparam int SRC_POS_LSB  = 3;
    localparam int SRC_POS_W    = 2;
    localparam int UNI_DST_LSB  = 5;
    localparam int UNI_DST_W    = 5;
    localparam int MULT_DST_LSB = 10;
    localparam int MULT_DST_W   = 20;

    typedef enum logic [1:0] {
        FT_BODY     = 2'd0,
        FT_HEAD     = 2'd1,
        FT_TAIL     = 2'd2,
        FT_HEADTAIL = 2'd3
    } flit_type_e;

    typedef enum logic [1:0] {
        UMESH_NONE     = 2'd0,
        UMESH_MULT_ROW = 2'd1,
        UMESH_MULT_COL = 2'd2,
        UMESH_MULT_ALL = 2'd3
    } umesh_state_e;

    typedef enum logic [1:0] {
        UNICAST = 2'd0,
        MULTFWD = 2'd1,
        MULTABS = 2'd2
    } multab_en_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUTE  = 2'd1,
        ST_SEND   = 2'd2,
        ST_REWIND = 2'd3
    } ib_state_e;

    function automatic logic is_head(input logic [1:0] ft);
        return (ft == FT_HEAD) || (ft == FT_HEADTAIL);
    endfunction

    function automatic logic is_tail(input logic [1:0] ft);
        return (ft == FT_TAIL) || (ft == FT_HEADTAIL);
    endfunction

endpackage

// File: rtl/ib_replay_buf.sv
// ---------------------------------------------------------------------------
// ib_replay_buf
//   DEPTH x FLITW flit store with three pointers so a packet can be read
//   more than once before its slots are released.
//     wr_ptr   : next slot to write
//     rd_ptr   : next slot to present (moves back on rewind)
//     free_ptr : oldest slot still owned by an unfinished packet
//   Pointers carry one extra wrap bit; occupancy = wr_ptr - free_ptr.
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   wr_en, wr_data  write request (ignored when full)
//   rd_inc          advance rd_ptr (flit consumed)
//   mark            remember rd_ptr as packet start
//   rewind          rd_ptr <= packet start
//   drop            discard flit at rd_ptr (rd_ptr and free_ptr advance)
//   commit          release slots up to the post-increment rd_ptr
//   rd_data         flit at rd_ptr (combinational read)
//   rd_avail        flit at rd_ptr has been written
//   not_full        free slots > 0, from registered pointers
// ---------------------------------------------------------------------------
module ib_replay_buf #(
    parameter int DEPTH = 8,
    parameter int FLITW = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [FLITW-1:0] wr_data,
    input  logic             rd_inc,
    input  logic             mark,
    input  logic             rewind,
    input  logic             drop,
    input  logic             commit,
    output logic [FLITW-1:0] rd_data,
    output logic             rd_avail,
    output logic             not_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);

    logic [FLITW-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] free_ptr_reg;
    logic [PW-1:0] start_ptr_reg;
    logic [PW-1:0] rd_ptr_next;
    logic [PW-1:0] occ;
    logic          do_write;

    assign occ      = wr_ptr_reg - free_ptr_reg;
    assign not_full = (occ != PTR_FULL);
    assign rd_avail = (rd_ptr_reg != wr_ptr_reg);
    assign do_write = wr_en && not_full;

    // Read is combinational so the FSM can inspect the flit type in the
    // same cycle it becomes visible; this keeps the head-to-ROUTE latency
    // at two cycles and lets a rewind re-present the head immediately.
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        if (rewind) begin
            rd_ptr_next = start_ptr_reg;
        end else if (rd_inc || drop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            free_ptr_reg  <= '0;
            start_ptr_reg <= '0;
        end else begin
            if (do_write) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            rd_ptr_reg <= rd_ptr_next;
            if (mark) begin
                start_ptr_reg <= rd_ptr_reg;
            end
            // Commit coincides with the tail being consumed, so the release
            // point is the already-advanced read pointer.
            if (drop || commit) begin
                free_ptr_reg <= rd_ptr_next;
            end
        end
    end

    // Storage has no reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/ib_mcast_split.sv
// ---------------------------------------------------------------------------
// ib_mcast_split
//   Input-channel controller in front of dec_hl. Buffers flits, presents the
//   head's route fields to dec_hl for one ROUTE cycle, latches the decision
//   and streams the packet out. A U-mesh multicast with a non-zero doc_remain
//   is replayed from the buffer with the head's mult_dst replaced by the
//   remainder; buffer slots are released only after the last copy leaves.
// Optional feature: define MCAST_SPLIT_STATS_EN to add split_cnt[15:0],
//   a saturating count of replays (REWIND entries).
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   in_flit/in_valid/in_ready   upstream flit interface
//   dec_um_type/uni_dst/mult_dst/src_pos   route fields to dec_hl (ROUTE only)
//   dec_port/doc_send/doc_remain/umesh_state/multab_en   dec_hl decision
//   out_flit/out_valid/out_ready            flit to switch
//   out_port, out_multab_en                 latched decision for current copy
// ---------------------------------------------------------------------------
module ib_mcast_split
    import hl_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int FLITW   = 64,
    parameter int MY_XPOS = 0,
    parameter int MY_YPOS = 0
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MCAST_SPLIT_STATS_EN
    output logic [15:0]      split_cnt,
`endif
    input  logic [FLITW-1:0] in_flit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dec_um_type,
    output logic [4:0]       dec_uni_dst,
    output logic [19:0]      dec_mult_dst,
    output logic [1:0]       dec_src_pos,
    input  logic [2:0]       dec_port,
    input  logic [19:0]      dec_doc_send,
    input  logic [19:0]      dec_doc_remain,
    input  logic [1:0]       dec_umesh_state,
    input  logic [1:0]       dec_multab_en,
    output logic [FLITW-1:0] out_flit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_port,
    output logic [1:0]       out_multab_en
);

    // The router position is consumed by dec_hl; here it is only range-checked.
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || FLITW < 30 ||
        MY_XPOS < 0 || MY_YPOS < 0) begin : g_bad_cfg
        $error("ib_mcast_split: illegal parameter set");
    end

    ib_state_e        state_reg, state_next;
    logic [19:0]      cur_mdst_reg;
    logic [2:0]       port_reg;
    logic [1:0]       multab_reg;
    logic [19:0]      doc_send_reg;
    logic [19:0]      doc_remain_reg;
    logic [1:0]       umesh_reg;
    logic             mcast_reg;

    logic [FLITW-1:0] rd_data;
    logic             rd_avail;
    logic             rd_inc, mark, rewind, drop, commit;
    logic [1:0]       rd_type;

    assign rd_type = rd_data[FT_LSB +: FT_W];

    ib_replay_buf #(
        .DEPTH (DEPTH),
        .FLITW (FLITW)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (in_valid),
        .wr_data  (in_flit),
        .rd_inc   (rd_inc),
        .mark     (mark),
        .rewind   (rewind),
        .drop     (drop),
        .commit   (commit),
        .rd_data  (rd_data),
        .rd_avail (rd_avail),
        .not_full (in_ready)
    );

    always_comb begin
        state_next   = state_reg;
        rd_inc       = 1'b0;
        mark         = 1'b0;
        rewind       = 1'b0;
        drop         = 1'b0;
        commit       = 1'b0;
        out_valid    = 1'b0;
        dec_um_type  = 1'b0;
        dec_uni_dst  = '0;
        dec_mult_dst = '0;
        dec_src_pos  = '0;
        unique case (state_reg)
            ST_IDLE: begin
                if (rd_avail) begin
                    if (is_head(rd_type)) begin
                        mark       = 1'b1;
                        state_next = ST_ROUTE;
                    end else begin
                        // Orphan body/tail: discard to resynchronise.
                        drop = 1'b1;
                    end
                end
            end
            ST_ROUTE: begin
                // rd_ptr still sits on the head here.
                dec_um_type  = rd_data[UM_TYPE_BIT];
                dec_uni_dst  = rd_data[UNI_DST_LSB +: UNI_DST_W];
                dec_src_pos  = rd_data[SRC_POS_LSB +: SRC_POS_W];
                dec_mult_dst = cur_mdst_reg;
                state_next   = ST_SEND;
            end
            ST_SEND: begin
                out_valid = rd_avail;
                if (rd_avail && out_ready) begin
                    rd_inc = 1'b1;
                    if (is_tail(rd_type)) begin
                        if (mcast_reg && (umesh_reg != UMESH_MULT_ROW) &&
                            (doc_remain_reg != '0)) begin
                            state_next = ST_REWIND;
                        end else begin
                            commit     = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end
                end
            end
            ST_REWIND: begin
                rewind     = 1'b1;
                state_next = ST_ROUTE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Only the head of a multicast copy carries the per-copy destination set.
    always_comb begin
        out_flit = rd_data;
        if (mcast_reg && is_head(rd_type)) begin
            out_flit[MULT_DST_LSB +: MULT_DST_W] = doc_send_reg;
        end
    end

    assign out_port      = port_reg;
    assign out_multab_en = multab_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cur_mdst_reg   <= '0;
            port_reg       <= '0;
            multab_reg     <= UNICAST;
            doc_send_reg   <= '0;
            doc_remain_reg <= '0;
            umesh_reg      <= UMESH_NONE;
            mcast_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (mark) begin
                cur_mdst_reg <= rd_data[MULT_DST_LSB +: MULT_DST_W];
            end else if (rewind) begin
                cur_mdst_reg <= doc_remain_reg;
            end
            if (state_reg == ST_ROUTE) begin
                port_reg       <= dec_port;
                multab_reg     <= dec_multab_en;
                doc_send_reg   <= dec_doc_send;
                doc_remain_reg <= dec_doc_remain;
                umesh_reg      <= dec_umesh_state;
                mcast_reg      <= rd_data[UM_TYPE_BIT];
            end
        end
    end

`ifdef MCAST_SPLIT_STATS_EN
    logic [15:0] split_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            split_cnt_reg <= '0;
        end else if (state_reg == ST_REWIND && split_cnt_reg != 16'hFFFF) begin
            split_cnt_reg <= split_cnt_reg + 16'd1;
        end
    end

    assign split_cnt = split_cnt_reg;
`endif

endmodule

// File: tb/tb_ib_mcast_split.sv
// ---------------------------------------------------------------------------
// tb_ib_mcast_split
//   Directed bench for ib_mcast_split. A small dec_hl stand-in answers route
//   requests: multicast destinations overlapping SPLIT_MASK are split into
//   (mask part, rest); otherwise the whole set is sent with nothing remaining.
//   Inputs change on the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_ib_mcast_split;
    import hl_pkg::*;

    localparam logic [19:0] SPLIT_MASK = 20'h00F00;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_flit;
    logic        in_valid;
    logic        in_ready;
    logic        dec_um_type;
    logic [4:0]  dec_uni_dst;
    logic [19:0] dec_mult_dst;
    logic [1:0]  dec_src_pos;
    logic [2:0]  dec_port;
    logic [19:0] dec_doc_send;
    logic [19:0] dec_doc_remain;
    logic [1:0]  dec_umesh_state;
    logic [1:0]  dec_multab_en;
    logic [63:0] out_flit;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_port;
    logic [1:0]  out_multab_en;
    logic [1:0]  umesh_v;
`ifdef MCAST_SPLIT_STATS_EN
    logic [15:0] split_cnt;
`endif

    int nvec = 0;
    int nerr = 0;
    logic [63:0] oq[$];
    logic [63:0] v4[8];
    logic [63:0] v5[4];
    logic [63:0] f;

    always #5 clk = ~clk;

    ib_mcast_split #(.DEPTH(8), .FLITW(64), .MY_XPOS(0), .MY_YPOS(0)) dut (
        .clk             (clk),
        .rst             (rst),
`ifdef MCAST_SPLIT_STATS_EN
        .split_cnt       (split_cnt),
`endif
        .in_flit         (in_flit),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .dec_um_type     (dec_um_type),
        .dec_uni_dst     (dec_uni_dst),
        .dec_mult_dst    (dec_mult_dst),
        .dec_src_pos     (dec_src_pos),
        .dec_port        (dec_port),
        .dec_doc_send    (dec_doc_send),
        .dec_doc_remain  (dec_doc_remain),
        .dec_umesh_state (dec_umesh_state),
        .dec_multab_en   (dec_multab_en),
        .out_flit        (out_flit),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_port        (out_port),
        .out_multab_en   (out_multab_en)
    );

    // dec_hl stand-in: unicast -> port 3; multicast copy touching the mask ->
    // port 2, otherwise port 4.
    always_comb begin
        dec_doc_send   = dec_mult_dst;
        dec_doc_remain = '0;
        if ((dec_mult_dst & SPLIT_MASK) != '0 && (dec_mult_dst & ~SPLIT_MASK) != '0) begin
            dec_doc_send   = dec_mult_dst & SPLIT_MASK;
            dec_doc_remain = dec_mult_dst & ~SPLIT_MASK;
        end
        if (!dec_um_type)                          dec_port = 3'd3;
        else if ((dec_mult_dst & SPLIT_MASK) != 0) dec_port = 3'd2;
        else                                       dec_port = 3'd4;
        dec_multab_en   = dec_um_type ? 2'd1 : 2'd0;
        dec_umesh_state = umesh_v;
    end

    // Accepted flits, in order.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) oq.push_back(out_flit);
    end

    function automatic logic [63:0] mk(input logic [1:0] ft, input logic um,
                                       input logic [1:0] src, input logic [4:0] uni,
                                       input logic [19:0] mdst, input logic [33:0] pl);
        return {pl, mdst, uni, src, um, ft};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for n accepted flits, then idle a little so duplicates show.
    task automatic drain(input string tag, input int n, input int budget);
        int c = 0;
        while (oq.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        nclk(6);
        chk(tag, 64'(oq.size()), 64'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_flit = '0; out_ready = 1'b0;
        umesh_v = UMESH_MULT_COL;
        nclk(2);
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_port", out_port, 0);
        chk("rst out_multab_en", out_multab_en, UNICAST);
        chk("rst dec_*", {dec_um_type, dec_uni_dst, dec_mult_dst, dec_src_pos}, 0);
`ifdef MCAST_SPLIT_STATS_EN
        chk("rst split_cnt", split_cnt, 0);
`endif
        rst = 1'b0;
        nclk(1);

        // 1: unicast HEAD/BODY/TAIL to node 5
        oq.delete(); out_ready = 1'b1;
        in_valid = 1'b1; in_flit = mk(FT_HEAD, 0, 2'd1, 5'd5, 20'h0, 34'h1111);
        @(negedge clk); in_flit = mk(FT_BODY, 0, 2'd0, 5'd0, 20'h0, 34'h2222);
        @(negedge clk);
        chk("t1 dec_uni_dst", dec_uni_dst, 5);
        chk("t1 dec_um_type", dec_um_type, 0);
        chk("t1 dec_src_pos", dec_src_pos, 1);
        chk("t1 no early out_valid", out_valid, 0);
        in_flit = mk(FT_TAIL, 0, 2'd0, 5'd0, 20'h0, 34'h3333);
        @(negedge clk); in_valid = 1'b0;
        chk("t1 out_valid at t+3", out_valid, 1);
        chk("t1 head", out_flit, mk(FT_HEAD, 0, 2'd1, 5'd5, 20'h0, 34'h1111));
        chk("t1 out_port", out_port, 3);
        drain("t1 count", 3, 20);
        chk("t1 body", oq[1], mk(FT_BODY, 0, 2'd0, 5'd0, 20'h0, 34'h2222));
        chk("t1 tail", oq[2], mk(FT_TAIL, 0, 2'd0, 5'd0, 20'h0, 34'h3333));
        chk("t1 idle", out_valid, 0);

        // 2: multicast HEADTAIL split into two copies
        oq.delete(); umesh_v = UMESH_MULT_COL;
        in_valid = 1'b1; in_flit = mk(FT_HEADTAIL, 1, 2'd2, 5'd0, 20'h00F0F, 34'h4444);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        chk("t2 dec_mult_dst copy1", dec_mult_dst, 20'h00F0F);
        chk("t2 dec_um_type", dec_um_type, 1);
        @(negedge clk);
        chk("t2 copy1 valid", out_valid, 1);
        chk("t2 copy1 head", out_flit, mk(FT_HEADTAIL, 1, 2'd2, 5'd0, 20'h00F00, 34'h4444));
        chk("t2 copy1 port", out_port, 2);
        chk("t2 copy1 multab", out_multab_en, MULTFWD);
        @(negedge clk);
        chk("t2 rewind gap", out_valid, 0);
        @(negedge clk);
        chk("t2 dec_mult_dst copy2", dec_mult_dst, 20'h0000F);
        @(negedge clk);
        chk("t2 copy2 head", out_flit, mk(FT_HEADTAIL, 1, 2'd2, 5'd0, 20'h0000F, 34'h4444));
        chk("t2 copy2 port", out_port, 4);
        drain("t2 count", 2, 20);
`ifdef MCAST_SPLIT_STATS_EN
        chk("t2 split_cnt", split_cnt, 1);
`endif

        // 3: U-mesh row multicast -> single copy
        oq.delete(); umesh_v = UMESH_MULT_ROW;
        in_valid = 1'b1; in_flit = mk(FT_HEADTAIL, 1, 2'd0, 5'd0, 20'h00F0F, 34'h5555);
        @(negedge clk); in_valid = 1'b0;
        drain("t3 count", 1, 20);
        chk("t3 head", oq[0], mk(FT_HEADTAIL, 1, 2'd0, 5'd0, 20'h00F00, 34'h5555));
        chk("t3 idle", out_valid, 0);
        umesh_v = UMESH_MULT_COL;

        // 4: fill with out_ready=0, then release
        oq.delete(); out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 0)      f = mk(FT_HEAD, 0, 2'd0, 5'd7, 20'h0, 34'(16'hA000 + i));
            else if (i % 4 == 3) f = mk(FT_TAIL, 0, 2'd0, 5'd0, 20'h0, 34'(16'hA000 + i));
            else                 f = mk(FT_BODY, 0, 2'd0, 5'd0, 20'h0, 34'(16'hA000 + i));
            v4[i] = f;
        end
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_flit = v4[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("t4 full after 8", in_ready, 0);
        out_ready = 1'b1;
        nclk(3);
        chk("t4 full until tail", in_ready, 0);
        nclk(1);
        chk("t4 ready after free", in_ready, 1);
        drain("t4 count", 8, 40);
        for (int i = 0; i < 8; i++) chk($sformatf("t4 flit%0d", i), oq[i], v4[i]);

        // 5: out_ready toggling during a 4-flit packet
        oq.delete();
        v5[0] = mk(FT_HEAD, 0, 2'd3, 5'd9, 20'h0, 34'hB0);
        v5[1] = mk(FT_BODY, 0, 2'd0, 5'd0, 20'h0, 34'hB1);
        v5[2] = mk(FT_BODY, 0, 2'd0, 5'd0, 20'h0, 34'hB2);
        v5[3] = mk(FT_TAIL, 0, 2'd0, 5'd0, 20'h0, 34'hB3);
        for (int c = 0; c < 20; c++) begin
            in_valid = (c < 4);
            if (c < 4) in_flit = v5[c];
            out_ready = (c % 2 == 1);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain("t5 count", 4, 20);
        for (int i = 0; i < 4; i++) chk($sformatf("t5 flit%0d", i), oq[i], v5[i]);

        // 6: reset during copy 2 of a split multicast
        oq.delete(); umesh_v = UMESH_MULT_COL;
        in_valid = 1'b1; in_flit = mk(FT_HEADTAIL, 1, 2'd2, 5'd0, 20'h00F0F, 34'h6666);
        @(negedge clk); in_valid = 1'b0;
        nclk(5);
        chk("t6 copy2 valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("t6 rst out_valid", out_valid, 0);
        chk("t6 rst in_ready", in_ready, 1);
`ifdef MCAST_SPLIT_STATS_EN
        chk("t6 rst split_cnt", split_cnt, 0);
`endif
        @(negedge clk); rst = 1'b0;
        oq.delete();
        @(negedge clk);
        in_valid = 1'b1; in_flit = mk(FT_HEADTAIL, 0, 2'd1, 5'd9, 20'h0, 34'h7777);
        @(negedge clk); in_valid = 1'b0;
        drain("t6 post-rst count", 1, 20);
        chk("t6 post-rst flit", oq[0], mk(FT_HEADTAIL, 0, 2'd1, 5'd9, 20'h0, 34'h7777));
        chk("t6 post-rst port", out_port, 3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
